// File: rtl/axi4l_master_arbiter_if.sv
// AXI4-Lite bus bundle for axi4l_master_arbiter: all five channels, with
// master (arbiter side) and slave (register block side) views.
interface axi4l_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4l_master_arbiter.sv
// Two-requester round-robin front end for one AXI4-Lite master port, one transaction in flight.
// Define AXI4L_ARB_TIMEOUT_EN to add a watchdog that ends a stalled transfer with SLVERR.
module axi4l_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req,
  input  logic [1:0]                    req_we,
  input  logic [2*ADDR_WIDTH-1:0]       req_addr,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [1:0]                    ack,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  axi4l_master_arbiter_if.master        axi
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2 || DATA_WIDTH % 8 != 0) begin : g_param_check
    $error("axi4l_master_arbiter: TIMEOUT_CYCLES must be >= 2 and DATA_WIDTH a multiple of 8");
  end

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [1:0]              ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

  // Arbitration: a lone requester wins outright; on a tie the one not served last wins.
  logic                  sel, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;

  assign sel       = (req == 2'b11) ? ~last_grant_q : req[1];
  assign sel_we    = req_we[sel];
  assign sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]   : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign sel_wstrb = sel ? req_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : req_wstrb[STRB_WIDTH-1:0];

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q & axi.AWREADY;
  assign w_hs   = wvalid_q  & axi.WREADY;
  assign b_hs   = bready_q  & axi.BVALID;
  assign ar_hs  = arvalid_q & axi.ARREADY;
  assign r_hs   = rready_q  & axi.RVALID;
  // A write channel is finished once its VALID has dropped or it handshakes this cycle.
  assign aw_fin = ~awvalid_q | axi.AWREADY;
  assign w_fin  = ~wvalid_q  | axi.WREADY;

  logic timeout;

`ifdef AXI4L_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             in_wait, any_hs;

  assign in_wait = (state_q == WR) || (state_q == WR_RESP) || (state_q == RD) || (state_q == RD_DATA);
  assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign timeout = in_wait && !any_hs && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin : watchdog
    if (rst || !in_wait || any_hs) wd_cnt_q <= '0;
    else                           wd_cnt_q <= wd_cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin : state_register
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : next_state_logic
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req)            state_d = sel_we ? WR : RD;
      WR:      if (aw_fin && w_fin) state_d = WR_RESP;
      WR_RESP: if (b_hs)            state_d = DONE;
      RD:      if (ar_hs)           state_d = RD_DATA;
      RD_DATA: if (r_hs)            state_d = DONE;
      DONE:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
    if (timeout) state_d = DONE;
  end

  always_comb begin : output_logic
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    araddr_d     = araddr_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    ack_d        = 2'b00;
    case (state_q)
      IDLE: if (|req) begin
        grant_d      = sel;
        last_grant_d = sel;
        if (sel_we) begin
          awaddr_d  = sel_addr;
          wdata_d   = sel_wdata;
          wstrb_d   = sel_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          araddr_d  = sel_addr;
          arvalid_d = 1'b1;
        end
      end
      WR: begin
        if (aw_hs)           awvalid_d = 1'b0;
        if (w_hs)            wvalid_d  = 1'b0;
        if (aw_fin && w_fin) bready_d  = 1'b1;
      end
      WR_RESP: if (b_hs) begin
        resp_d         = axi.BRESP;
        bready_d       = 1'b0;
        ack_d[grant_q] = 1'b1;
      end
      RD: if (ar_hs) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
      end
      RD_DATA: if (r_hs) begin
        rdata_d        = axi.RDATA;
        resp_d         = axi.RRESP;
        rready_d       = 1'b0;
        ack_d[grant_q] = 1'b1;
      end
      default: ;
    endcase
    // Watchdog expiry abandons the bus transfer and reports SLVERR; read data is left alone.
    if (timeout) begin
      awvalid_d      = 1'b0;
      wvalid_d       = 1'b0;
      bready_d       = 1'b0;
      arvalid_d      = 1'b0;
      rready_d       = 1'b0;
      resp_d         = 2'b10;
      ack_d          = 2'b00;
      ack_d[grant_q] = 1'b1;
    end
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin : output_register
    if (rst) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      araddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      resp_q       <= 2'b00;
    end else begin
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      araddr_q     <= araddr_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign axi.AWADDR  = awaddr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;
  assign ack         = ack_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;

endmodule
